lamp_fpu_fract_div_arb: RTL and testbench



---
 rtl/lamp_fpu_fract_div_arb_if.sv | 33 +++
 rtl/lamp_fpu_fract_div_arb.sv | 115 +++++++++++
 tb/tb_lamp_fpu_fract_div_arb.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_fpu_fract_div_arb_if.sv
// Bundle between the requesters, the shared fractional divider and the arbiter.
// master: requesters plus the divider side; slave: the arbiter.
interface lamp_fpu_fract_div_arb_if #(
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int NREQ            = 2
);
  localparam int MW = 1 + LAMP_FLOAT_F_DW;
  localparam int RW = 2 * MW;

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ*MW-1:0] req_n_i;
  logic [NREQ*MW-1:0] req_d_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [NREQ-1:0]    rsp_ready_i;
  logic [NREQ*RW-1:0] rsp_res_o;
  logic               div_do_o;
  logic [MW-1:0]      div_n_o;
  logic [MW-1:0]      div_d_o;
  logic [RW-1:0]      div_res_i;
  logic               div_valid_i;
  logic               busy_o;

  modport master (
    output req_valid_i, req_n_i, req_d_i, rsp_ready_i, div_res_i, div_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, div_do_o, div_n_o, div_d_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_n_i, req_d_i, rsp_ready_i, div_res_i, div_valid_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, div_do_o, div_n_o, div_d_o, busy_o
  );
endinterface

// File: rtl/lamp_fpu_fract_div_arb.sv
// Round-robin sharing of one fractional divider among NREQ requesters, one job
// in flight, with a per-requester result buffer held until acknowledged.
module lamp_fpu_fract_div_arb #(
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int NREQ            = 2
) (
  input logic clk,
  input logic rst,
  lamp_fpu_fract_div_arb_if.slave bus
);
  localparam int MW = 1 + LAMP_FLOAT_F_DW;
  localparam int RW = 2 * MW;
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_reg;
  logic [IW-1:0]   last_grant_reg;
  logic [IW-1:0]   owner_reg;
  logic [MW-1:0]   op_n_reg;
  logic [MW-1:0]   op_d_reg;
  logic            div_do_reg;
  logic            busy_reg;
  logic            rsp_valid_reg [NREQ];
  logic [RW-1:0]   rsp_res_reg   [NREQ];

  logic [MW-1:0]   req_n [NREQ];
  logic [MW-1:0]   req_d [NREQ];
  logic [NREQ-1:0] elig;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  int              cand;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_n[gi] = bus.req_n_i[gi*MW +: MW];
      assign req_d[gi] = bus.req_d_i[gi*MW +: MW];
      // Registered rsp_valid keeps a requester out of arbitration while its result is pending.
      assign elig[gi]  = bus.req_valid_i[gi] & ~rsp_valid_reg[gi];
      assign bus.rsp_valid_o[gi]             = rsp_valid_reg[gi];
      assign bus.rsp_res_o[gi*RW +: RW]      = rsp_res_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_res_reg[gi]   <= '0;
        end else if (state_reg == WAIT && bus.div_valid_i && owner_reg == IW'(gi)) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_res_reg[gi]   <= bus.div_res_i;
        end else if (rsp_valid_reg[gi] && bus.rsp_ready_i[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Walk offsets downward so the smallest offset past last_grant wins.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = int'(last_grant_reg) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (elig[cand]) begin
        grant_idx   = IW'(cand);
        grant_found = 1'b1;
      end
    end
  end

  assign bus.req_ready_o = (state_reg == IDLE && !rst && grant_found)
                         ? (NREQ'(1) << grant_idx) : '0;
  assign bus.div_do_o = div_do_reg;
  assign bus.div_n_o  = op_n_reg;
  assign bus.div_d_o  = op_d_reg;
  assign bus.busy_o   = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NREQ - 1);
      owner_reg      <= '0;
      op_n_reg       <= '0;
      op_d_reg       <= '0;
      div_do_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            op_n_reg       <= req_n[grant_idx];
            op_d_reg       <= req_d[grant_idx];
            owner_reg      <= grant_idx;
            last_grant_reg <= grant_idx;
            div_do_reg     <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          div_do_reg <= 1'b0;
          state_reg  <= WAIT;
        end
        WAIT: begin
          if (bus.div_valid_i) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lamp_fpu_fract_div_arb.sv
// Bench for lamp_fpu_fract_div_arb (NREQ=3) with a 4-cycle divider stub and a
// timeline-level reference model of grants, completions and result buffers.
module tb_lamp_fpu_fract_div_arb;
  localparam int F  = 7;
  localparam int W  = F + 1;
  localparam int RW = 2 * W;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst;
  logic spur;
  always #5 clk = ~clk;

  lamp_fpu_fract_div_arb_if #(.LAMP_FLOAT_F_DW(F), .NREQ(N)) bus ();
  lamp_fpu_fract_div_arb #(.LAMP_FLOAT_F_DW(F), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Divider stub: result {n,d} pulses 4 cycles after div_do_o, cleared by the shared reset.
  logic [3:0]    stub_v;
  logic [RW-1:0] stub_d [4];
  always @(posedge clk) begin
    if (rst) stub_v <= '0;
    else     stub_v <= {stub_v[2:0], bus.div_do_o};
    stub_d[0] <= {bus.div_n_o, bus.div_d_o};
    for (int i = 1; i < 4; i++) stub_d[i] <= stub_d[i-1];
  end
  assign bus.div_valid_i = stub_v[3] | spur;
  assign bus.div_res_i   = stub_d[3];

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a job granted in cycle T yields its result in T+6 and frees the divider then.
  int            cyc = 0, free_at = 0, done_at = 0, do_at = 0, own_m = 0, last_m = N - 1;
  bit            job_m = 0;
  logic [N-1:0]  pend_m = '0;
  logic [RW-1:0] res_m [N];
  logic [W-1:0]  opn_m = '0, opd_m = '0;
  logic [RW-1:0] jres_m;

  logic [N-1:0]   e_ready, e_rsp_valid;
  logic [N*RW-1:0] e_res;
  logic           e_do, e_busy;
  logic [W-1:0]   e_n, e_d;

  int            g_order[$];
  int            g_cyc[$];
  logic [RW-1:0] g_res[$];

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] elig, input int last);
    for (int off = 1; off <= N; off++)
      if (elig[(last + off) % N]) return N'(1) << ((last + off) % N);
    return '0;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic rand_ops();
    bus.req_n_i = (N*W)'($urandom);
    bus.req_d_i = (N*W)'($urandom);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rr, input logic r);
    bus.req_valid_i = v;
    bus.rsp_ready_i = rr;
    rst = r;
    #1;
    e_ready     = (r || cyc < free_at) ? '0 : rr_pick(v & ~pend_m, last_m);
    e_rsp_valid = pend_m;
    for (int k = 0; k < N; k++) e_res[k*RW +: RW] = res_m[k];
    e_do   = job_m && (cyc == do_at);
    e_busy = job_m;
    e_n    = opn_m;
    e_d    = opd_m;
  endtask

  task automatic advance();
    logic [N-1:0] np;
    if (rst) begin
      pend_m = '0;
      for (int k = 0; k < N; k++) res_m[k] = '0;
      job_m = 0; last_m = N - 1; opn_m = '0; opd_m = '0; free_at = 0;
    end else begin
      np = pend_m & ~bus.rsp_ready_i;
      if (job_m && cyc + 1 == done_at) begin
        np[own_m] = 1'b1; res_m[own_m] = jres_m; job_m = 0;
      end
      pend_m = np;
      if (e_ready != '0) begin
        own_m  = oh_idx(e_ready);
        opn_m  = bus.req_n_i[own_m*W +: W];
        opd_m  = bus.req_d_i[own_m*W +: W];
        jres_m = {opn_m, opd_m};
        last_m = own_m; job_m = 1;
        do_at = cyc + 1; done_at = cyc + 6; free_at = cyc + 6;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b1);
    advance();
  endtask

  task automatic serve(input logic [N-1:0] v, input logic [N-1:0] rr, input int ncyc, output int mism);
    int k;
    mism = 0;
    for (int i = 0; i < ncyc; i++) begin
      rand_ops();
      drive(v, rr, 1'b0);
      if (bus.req_ready_o !== e_ready || bus.rsp_valid_o !== e_rsp_valid ||
          bus.rsp_res_o !== e_res || bus.div_do_o !== e_do || bus.busy_o !== e_busy) mism++;
      if (bus.req_ready_o != '0) begin
        k = oh_idx(bus.req_ready_o);
        g_order.push_back(k);
        g_cyc.push_back(cyc);
        g_res.push_back({bus.req_n_i[k*W +: W], bus.req_d_i[k*W +: W]});
      end
      advance();
    end
  endtask

  task automatic test_reset();
    drive('0, '0, 1'b1);
    advance();
    drive(3'b111, '0, 1'b1);
    n_total++; if (bus.req_ready_o !== 3'b000) $display("FAIL reset_ready got=%b want=000", bus.req_ready_o); else n_pass++;
    n_total++; if (bus.rsp_valid_o !== 3'b000) $display("FAIL reset_rsp_valid got=%b want=000", bus.rsp_valid_o); else n_pass++;
    n_total++; if (bus.rsp_res_o !== '0) $display("FAIL reset_rsp_res got=%h want=0", bus.rsp_res_o); else n_pass++;
    n_total++; if (bus.div_do_o !== 1'b0) $display("FAIL reset_div_do got=%b want=0", bus.div_do_o); else n_pass++;
    n_total++; if (bus.div_n_o !== '0) $display("FAIL reset_div_n got=%h want=0", bus.div_n_o); else n_pass++;
    n_total++; if (bus.div_d_o !== '0) $display("FAIL reset_div_d got=%h want=0", bus.div_d_o); else n_pass++;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy_o); else n_pass++;
    advance();
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    bus.req_n_i = '0; bus.req_d_i = '0;
    bus.req_n_i[W-1:0] = 8'hA5;
    bus.req_d_i[W-1:0] = 8'h3C;
    drive(3'b001, 3'b111, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b001) $display("FAIL single_grant got=%b want=001", bus.req_ready_o); else n_pass++;
    advance();
    for (int i = 1; i <= 7; i++) begin
      drive(3'b000, 3'b111, 1'b0);
      n_total++; if (bus.div_do_o !== (i == 1)) $display("FAIL single_div_do t+%0d got=%b want=%b", i, bus.div_do_o, (i == 1)); else n_pass++;
      n_total++; if (bus.busy_o !== (i <= 5)) $display("FAIL single_busy t+%0d got=%b want=%b", i, bus.busy_o, (i <= 5)); else n_pass++;
      n_total++; if (bus.rsp_valid_o[0] !== (i == 6)) $display("FAIL single_rsp_valid t+%0d got=%b want=%b", i, bus.rsp_valid_o[0], (i == 6)); else n_pass++;
      if (i == 6) begin
        n_total++; if (bus.rsp_res_o[RW-1:0] !== 16'hA53C) $display("FAIL single_rsp_res got=%h want=a53c", bus.rsp_res_o[RW-1:0]); else n_pass++;
      end
      advance();
    end
    $display("test_single done");
  endtask

  task automatic test_contention();
    int mism;
    do_reset();
    g_order.delete(); g_cyc.delete(); g_res.delete();
    serve(3'b011, 3'b111, 20, mism);
    n_total++; if (mism !== 0) $display("FAIL contention_model mismatched_cycles=%0d want=0", mism); else n_pass++;
    n_total++; if (g_order.size() < 3) $display("FAIL contention_count got=%0d want>=3", g_order.size()); else n_pass++;
    if (g_order.size() >= 3) begin
      n_total++; if (g_order[0] !== 0) $display("FAIL contention_first got=%0d want=0", g_order[0]); else n_pass++;
      n_total++; if (g_order[1] !== 1) $display("FAIL contention_second got=%0d want=1", g_order[1]); else n_pass++;
      n_total++; if (g_order[2] !== 0) $display("FAIL contention_third got=%0d want=0", g_order[2]); else n_pass++;
      n_total++; if (g_cyc[1] - g_cyc[0] !== 6) $display("FAIL contention_gap got=%0d want=6", g_cyc[1] - g_cyc[0]); else n_pass++;
    end
    $display("test_contention done grants=%0d", g_order.size());
  endtask

  task automatic test_backpressure();
    int mism, mism2, c0, c1;
    do_reset();
    g_order.delete(); g_cyc.delete(); g_res.delete();
    serve(3'b011, 3'b010, 30, mism);
    c0 = 0; c1 = 0;
    foreach (g_order[i]) if (g_order[i] == 0) c0++; else if (g_order[i] == 1) c1++;
    n_total++; if (mism !== 0) $display("FAIL bp_model mismatched_cycles=%0d want=0", mism); else n_pass++;
    n_total++; if (c0 !== 1) $display("FAIL bp_grants0 got=%0d want=1", c0); else n_pass++;
    n_total++; if (c1 < 3) $display("FAIL bp_grants1 got=%0d want>=3", c1); else n_pass++;
    serve(3'b000, 3'b010, 8, mism2);
    n_total++; if (mism2 !== 0) $display("FAIL bp_drain_model mismatched_cycles=%0d want=0", mism2); else n_pass++;
    n_total++; if (bus.rsp_valid_o[0] !== 1'b1) $display("FAIL bp_hold_valid got=%b want=1", bus.rsp_valid_o[0]); else n_pass++;
    if (g_res.size() > 0) begin
      n_total++; if (bus.rsp_res_o[RW-1:0] !== g_res[0]) $display("FAIL bp_hold_res got=%h want=%h", bus.rsp_res_o[RW-1:0], g_res[0]); else n_pass++;
    end
    drive(3'b001, 3'b001, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b000) $display("FAIL bp_same_cycle_regrant got=%b want=000", bus.req_ready_o); else n_pass++;
    advance();
    drive(3'b001, 3'b001, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b001) $display("FAIL bp_next_cycle_grant got=%b want=001", bus.req_ready_o); else n_pass++;
    advance();
    serve(3'b000, 3'b111, 10, mism);
    n_total++; if (mism !== 0) $display("FAIL bp_tail_model mismatched_cycles=%0d want=0", mism); else n_pass++;
    $display("test_backpressure done grants0=%0d grants1=%0d", c0, c1);
  endtask

  task automatic test_spurious();
    do_reset();
    drive('0, '0, 1'b0);
    advance();
    spur = 1'b1;
    drive('0, '0, 1'b0);
    advance();
    spur = 1'b0;
    drive('0, '0, 1'b0);
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL spur_busy got=%b want=0", bus.busy_o); else n_pass++;
    n_total++; if (bus.rsp_valid_o !== 3'b000) $display("FAIL spur_rsp_valid got=%b want=000", bus.rsp_valid_o); else n_pass++;
    n_total++; if (bus.div_do_o !== 1'b0) $display("FAIL spur_div_do got=%b want=0", bus.div_do_o); else n_pass++;
    advance();
    drive(3'b010, 3'b111, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b010) $display("FAIL spur_then_grant got=%b want=010", bus.req_ready_o); else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin drive('0, 3'b111, 1'b0); advance(); end
    $display("test_spurious done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_ops();
    drive(3'b100, 3'b111, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b100) $display("FAIL rstmid_grant got=%b want=100", bus.req_ready_o); else n_pass++;
    advance();
    drive('0, 3'b111, 1'b0); advance();
    drive('0, 3'b111, 1'b0);
    n_total++; if (bus.busy_o !== 1'b1) $display("FAIL rstmid_busy_before got=%b want=1", bus.busy_o); else n_pass++;
    advance();
    drive('0, 3'b111, 1'b1); advance();
    for (int i = 0; i < 8; i++) begin
      drive('0, 3'b111, 1'b0);
      if (i == 0) begin
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", bus.busy_o); else n_pass++;
        n_total++; if (bus.div_n_o !== '0 || bus.div_d_o !== '0) $display("FAIL rstmid_ops got=%h/%h want=0/0", bus.div_n_o, bus.div_d_o); else n_pass++;
        n_total++; if (bus.rsp_res_o !== '0) $display("FAIL rstmid_res got=%h want=0", bus.rsp_res_o); else n_pass++;
      end
      n_total++; if (bus.rsp_valid_o !== 3'b000) $display("FAIL rstmid_no_rsp cyc%0d got=%b want=000", i, bus.rsp_valid_o); else n_pass++;
      advance();
    end
    bus.req_n_i[2*W +: W] = 8'h5A;
    bus.req_d_i[2*W +: W] = 8'hC3;
    drive(3'b100, 3'b111, 1'b0);
    n_total++; if (bus.req_ready_o !== 3'b100) $display("FAIL rstmid_regrant got=%b want=100", bus.req_ready_o); else n_pass++;
    advance();
    for (int i = 1; i <= 6; i++) begin
      drive('0, 3'b111, 1'b0);
      if (i == 6) begin
        n_total++; if (bus.rsp_valid_o !== 3'b100) $display("FAIL rstmid_rsp_valid got=%b want=100", bus.rsp_valid_o); else n_pass++;
        n_total++; if (bus.rsp_res_o[2*RW +: RW] !== 16'h5AC3) $display("FAIL rstmid_rsp_res got=%h want=5ac3", bus.rsp_res_o[2*RW +: RW]); else n_pass++;
      end
      advance();
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    int mism;
    do_reset();
    g_order.delete(); g_cyc.delete(); g_res.delete();
    serve(3'b111, 3'b111, 40, mism);
    n_total++; if (mism !== 0) $display("FAIL wrap_model mismatched_cycles=%0d want=0", mism); else n_pass++;
    n_total++; if (g_order.size() < 6) $display("FAIL wrap_count got=%0d want>=6", g_order.size()); else n_pass++;
    if (g_order.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        n_total++; if (g_order[i] !== i % 3) $display("FAIL wrap_order[%0d] got=%0d want=%0d", i, g_order[i], i % 3); else n_pass++;
      end
    $display("test_wrap done grants=%0d", g_order.size());
  endtask

  task automatic test_random();
    logic [N-1:0] v, rr;
    logic r;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rand_ops();
      v  = N'($urandom);
      rr = N'($urandom);
      r  = ($urandom_range(0, 99) == 0);
      drive(v, rr, r);
      n_total++; if (bus.req_ready_o !== e_ready) $display("FAIL rand_ready cyc%0d got=%b want=%b", i, bus.req_ready_o, e_ready); else n_pass++;
      n_total++; if (bus.rsp_valid_o !== e_rsp_valid) $display("FAIL rand_rsp_valid cyc%0d got=%b want=%b", i, bus.rsp_valid_o, e_rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_res_o !== e_res) $display("FAIL rand_rsp_res cyc%0d got=%h want=%h", i, bus.rsp_res_o, e_res); else n_pass++;
      n_total++; if (bus.div_do_o !== e_do) $display("FAIL rand_div_do cyc%0d got=%b want=%b", i, bus.div_do_o, e_do); else n_pass++;
      n_total++; if (bus.busy_o !== e_busy) $display("FAIL rand_busy cyc%0d got=%b want=%b", i, bus.busy_o, e_busy); else n_pass++;
      n_total++; if ({bus.div_n_o, bus.div_d_o} !== {e_n, e_d}) $display("FAIL rand_div_ops cyc%0d got=%h want=%h", i, {bus.div_n_o, bus.div_d_o}, {e_n, e_d}); else n_pass++;
      advance();
    end
    $display("test_random done cycles=800");
  endtask

  initial begin
    for (int k = 0; k < N; k++) res_m[k] = '0;
    spur = 1'b0;
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    bus.req_n_i = '0;
    bus.req_d_i = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
